dlatch_checker: RTL and testbench
=================================

DLATCH_CHECKER -- requirements
Module: dlatch_checker

Interface
REQ-001 Parameter SAMPLES, default 20, is the number of sampled clock edges per check run (1..255).
REQ-002 Parameter CNT_W, default 8, is the width of the sample and error counters.
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port start, input, 1, is a one-cycle pulse that begins a run; it is honoured in IDLE or DONE only.
REQ-006 Port en, input, 1, is the observed latch enable.
REQ-007 Port d_in, input, 1, is the observed latch data input.
REQ-008 Port rb, input, 1, is the observed active-low reset of the latch.
REQ-009 Port sb, input, 1, is the observed active-low set of the latch.
REQ-010 Port q, input, 1, is the observed latch Q.
REQ-011 Port qbar, input, 1, is the observed latch Qbar.
REQ-012 Port busy, output, 1, is high while in RUN.
REQ-013 Port done, output, 1, is high while in DONE.
REQ-014 Port err_pulse, output, 1, is a one-cycle pulse per detected mismatch.
REQ-015 Port err_count, output, CNT_W, is the mismatch count of the current or last run.
REQ-016 Port first_err, output, CNT_W, is the sample index of the first mismatch, or all-ones if there was none.
REQ-017 Port illegal, output, 1, is a sticky flag: rb=0 and sb=0 were seen during the run.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start.
- RUN->DONE on the edge that takes sample SAMPLES-1.
- DONE->RUN on start.
- RUN ignores start.
REQ-019 On entering RUN, the block SHALL clear the sample index, err_count, illegal and the model-valid flag, and set first_err to all-ones.
REQ-020 In RUN, the block SHALL sample all observed inputs at every rising edge and compute the expected (eq, eqb) from those samples and the held model state m:
- rb=0, sb=0: eq=1, eqb=1; sets illegal.
- sb=0, rb=1: eq=1, eqb=0; m<=1; model valid.
- rb=0, sb=1: eq=0, eqb=1; m<=0; model valid.
- rb=1, sb=1, en=1: eq=d_in, eqb=~d_in; m<=d_in; model valid.
- rb=1, sb=1, en=0: eq=m, eqb=~m; hold.
REQ-021 When rb=sb=1 and en=0 immediately follows an rb=sb=0 sample, the block SHALL clear model-valid, because the latch state is then undefined.
REQ-022 The block SHALL compare only when model-valid is set, or when the current sample is not a hold case; otherwise it SHALL skip the comparison.
REQ-023 A mismatch is (q,qbar)!=(eq,eqb); each mismatch SHALL assert err_pulse exactly one cycle after the sampling edge.
REQ-024 err_count SHALL increment once per mismatch and saturate at 2^CNT_W-1 without wrapping.
REQ-025 first_err SHALL latch the sample index only on the first mismatch of a run.
REQ-026 The model state m SHALL be undefined until the first set, reset or enabled sample; hold samples before that point SHALL be skipped.
REQ-027 In IDLE and DONE, the block SHALL perform no sampling or comparison and SHALL hold err_count, first_err and illegal.
REQ-028 A start coinciding with the final RUN sample SHALL be ignored; the block SHALL enter DONE.

Reset
REQ-029 On rst high, asynchronously and regardless of clk, the block SHALL set:
- state=IDLE, busy=0, done=0, err_pulse=0.
- err_count=0, first_err=all-ones, illegal=0.
- m=0, model-valid=0.
REQ-030 rst asserted mid-run SHALL abort the run; no partial results are kept.
REQ-031 After rst deasserts, the block SHALL take no action until a start pulse.

Verification
REQ-032 Run with the latch modelled correctly: 20 samples of toggling en, d_in, rb and sb -> done=1 after 20 edges, err_count=0, first_err=8'hFF.
REQ-033 Run with q stuck at 0 and sb=0 at sample 3 -> err_pulse at edge 4, first_err=3, err_count>=1.
REQ-034 Run with rb=sb=0 at sample 5 then hold -> illegal=1, and no error is counted on the following hold samples.
REQ-035 Inject 300 mismatches with SAMPLES=255 and CNT_W=8 across consecutive runs -> err_count saturates at 255 within a run, never wraps, and restarts at 0 on the next start.
REQ-036 Assert rst at sample 10 of a run -> busy=0, err_count=0 and first_err=8'hFF immediately; start then begins a fresh run at sample 0.
REQ-037 Pulse start during RUN at sample 7 -> no restart; done asserts at the original sample SAMPLES-1.

Source files
------------

// File: rtl/dlatch_checker.sv
// Runtime checker for a D latch with active-low set/reset: samples the latch
// pins for SAMPLES edges per run and counts (q,qbar) mismatches against a model.
module dlatch_checker #(
  parameter int unsigned SAMPLES = 20,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             d_in,
  input  logic             rb,
  input  logic             sb,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err,
  output logic             illegal
);

  localparam int unsigned      IDX_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q, done_q, err_pulse_q, illegal_q;
  logic [CNT_W-1:0] err_count_q, first_err_q;
  logic             m_q, mv_q, prev_ill_q;

  logic             eq, eqb, is_hold, both_low, m_d, mv_d, do_cmp, mismatch;
  logic [CNT_W-1:0] err_count_d, first_err_d;

  always_comb begin
    eq       = 1'b0;
    eqb      = 1'b0;
    is_hold  = 1'b0;
    m_d      = m_q;
    mv_d     = mv_q;
    both_low = ~rb & ~sb;
    case ({rb, sb})
      2'b00: begin
        eq  = 1'b1;
        eqb = 1'b1;
      end
      2'b10: begin
        eq   = 1'b1;
        eqb  = 1'b0;
        m_d  = 1'b1;
        mv_d = 1'b1;
      end
      2'b01: begin
        eq   = 1'b0;
        eqb  = 1'b1;
        m_d  = 1'b0;
        mv_d = 1'b1;
      end
      default: begin
        if (en) begin
          eq   = d_in;
          eqb  = ~d_in;
          m_d  = d_in;
          mv_d = 1'b1;
        end else begin
          // Holding straight after set+reset both low leaves the latch undefined.
          eq      = m_q;
          eqb     = ~m_q;
          is_hold = 1'b1;
          if (prev_ill_q) mv_d = 1'b0;
        end
      end
    endcase
    do_cmp      = ~is_hold | mv_d;
    mismatch    = do_cmp & ({q, qbar} != {eq, eqb});
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if (mismatch) begin
      if (err_count_q != '1)  err_count_d = err_count_q + CNT_W'(1);
      if (err_count_q == '0)  first_err_d = CNT_W'(idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '1;
      illegal_q   <= 1'b0;
      m_q         <= 1'b0;
      mv_q        <= 1'b0;
      prev_ill_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          err_pulse_q <= mismatch;
          err_count_q <= err_count_d;
          first_err_q <= first_err_d;
          illegal_q   <= illegal_q | both_low;
          m_q         <= m_d;
          mv_q        <= mv_d;
          prev_ill_q  <= both_low;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          err_pulse_q <= 1'b0;
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            idx_q       <= '0;
            err_count_q <= '0;
            first_err_q <= '1;
            illegal_q   <= 1'b0;
            mv_q        <= 1'b0;
            prev_ill_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign first_err = first_err_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_dlatch_checker.sv
// Bench for dlatch_checker: three instances (default, 255-sample, 4-bit counters)
// checked every cycle against a behavioural model plus directed literal checks.
module tb_dlatch_checker;

  localparam int NI = 3;
  localparam int M_S   [NI] = '{20, 255, 20};
  localparam int M_MAX [NI] = '{255, 255, 15};

  logic clk = 1'b0;
  logic rst;
  logic st_a, st_b, en, d_in, rb, sb, q, qbar;

  logic       busy0, done0, pul0, ill0;
  logic [7:0] ec0, fe0;
  logic       busy1, done1, pul1, ill1;
  logic [7:0] ec1, fe1;
  logic       busy2, done2, pul2, ill2;
  logic [3:0] ec2, fe2;

  int n_pass  = 0;
  int n_total = 0;
  bit gq      = 1'b0;

  always #5 clk = ~clk;

  dlatch_checker #(.SAMPLES(20), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(st_a), .en(en), .d_in(d_in), .rb(rb), .sb(sb),
    .q(q), .qbar(qbar), .busy(busy0), .done(done0), .err_pulse(pul0),
    .err_count(ec0), .first_err(fe0), .illegal(ill0));

  dlatch_checker #(.SAMPLES(255), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(st_b), .en(en), .d_in(d_in), .rb(rb), .sb(sb),
    .q(q), .qbar(qbar), .busy(busy1), .done(done1), .err_pulse(pul1),
    .err_count(ec1), .first_err(fe1), .illegal(ill1));

  dlatch_checker #(.SAMPLES(20), .CNT_W(4)) u_narrow (
    .clk(clk), .rst(rst), .start(st_a), .en(en), .d_in(d_in), .rb(rb), .sb(sb),
    .q(q), .qbar(qbar), .busy(busy2), .done(done2), .err_pulse(pul2),
    .err_count(ec2), .first_err(fe2), .illegal(ill2));

  // st: 0 idle, 1 run, 2 done; lat: -1 means latch value unknown
  typedef struct {
    int st, idx, ec, fe, lat;
    bit ill, pul;
  } mstate_t;

  mstate_t ms [NI];

  function automatic mstate_t mreset(int k);
    mstate_t n;
    n.st = 0; n.idx = 0; n.ec = 0; n.fe = M_MAX[k]; n.lat = -1;
    n.ill = 1'b0; n.pul = 1'b0;
    return n;
  endfunction

  function automatic mstate_t mstep(mstate_t c, int k, bit stt);
    mstate_t n = c;
    int e0 = 0;
    int e1 = 0;
    bit cmp = 1'b1;
    if (c.st == 1) begin
      if (!rb && !sb) begin e0 = 1; e1 = 1; n.ill = 1'b1; n.lat = -1; end
      else if (!sb)   begin e0 = 1; e1 = 0; n.lat = 1; end
      else if (!rb)   begin e0 = 0; e1 = 1; n.lat = 0; end
      else if (en)    begin e0 = int'(d_in); e1 = 1 - int'(d_in); n.lat = int'(d_in); end
      else if (c.lat < 0) cmp = 1'b0;
      else begin e0 = c.lat; e1 = 1 - c.lat; end
      n.pul = cmp && (int'(q) != e0 || int'(qbar) != e1);
      if (n.pul) begin
        if (c.ec == 0) n.fe = c.idx & M_MAX[k];
        if (c.ec < M_MAX[k]) n.ec = c.ec + 1;
      end
      if (c.idx == M_S[k] - 1) n.st = 2;
      else n.idx = c.idx + 1;
    end else begin
      n.pul = 1'b0;
      if (stt) begin
        n.st = 1; n.idx = 0; n.ec = 0; n.fe = M_MAX[k]; n.ill = 1'b0; n.lat = -1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) ms[k] <= mreset(k);
    end else begin
      for (int k = 0; k < NI; k++) ms[k] <= mstep(ms[k], k, (k == 1) ? st_b : st_a);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_inst(input string nm, input logic b, input logic dn, input logic p,
                          input int ec, input int fe, input logic il, input mstate_t m);
    chk({nm, ".busy"}, int'(b), int'(m.st == 1));
    chk({nm, ".done"}, int'(dn), int'(m.st == 2));
    chk({nm, ".err_pulse"}, int'(p), int'(m.pul));
    chk({nm, ".err_count"}, ec, m.ec);
    chk({nm, ".first_err"}, fe, m.fe);
    chk({nm, ".illegal"}, int'(il), int'(m.ill));
  endtask

  always @(negedge clk) begin
    cmp_inst("dut", busy0, done0, pul0, int'(ec0), int'(fe0), ill0, ms[0]);
    cmp_inst("sat", busy1, done1, pul1, int'(ec1), int'(fe1), ill1, ms[1]);
    cmp_inst("nar", busy2, done2, pul2, int'(ec2), int'(fe2), ill2, ms[2]);
  end

  task automatic drive(input bit sa, input bit sbb, input bit e, input bit d,
                       input bit r, input bit s, input bit qq, input bit qb);
    @(posedge clk);
    #1;
    st_a = sa; st_b = sbb; en = e; d_in = d; rb = r; sb = s; q = qq; qbar = qb;
  endtask

  // Drives pins with the outputs a healthy latch would show for these inputs.
  task automatic good(input bit sa, input bit sbb, input bit e, input bit d,
                      input bit r, input bit s);
    bit qq, qb;
    if (!r && !s) begin qq = 1'b1; qb = 1'b1; end
    else begin
      if (!s) gq = 1'b1;
      else if (!r) gq = 1'b0;
      else if (e) gq = d;
      qq = gq; qb = ~gq;
    end
    drive(sa, sbb, e, d, r, s, qq, qb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_a = 1'b0; st_b = 1'b0; en = 1'b0; d_in = 1'b0;
    rb = 1'b1; sb = 1'b1; q = 1'b0; qbar = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_err_count", int'(ec0), 0);
    chk("rst_first_err", int'(fe0), 255);
    chk("rst_illegal", int'(ill0), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Correct latch, toggling controls.
    good(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) good(0, 0, i[0], i[1], !(i % 7 == 2), !(i % 5 == 3));
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("clean_done", int'(done0), 1);
    chk("clean_err_count", int'(ec0), 0);
    chk("clean_first_err", int'(fe0), 255);

    // q stuck at 0, set at sample 3.
    good(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) good(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("stuck_no_early_pulse", int'(pul0), 0);
    good(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("stuck_pulse", int'(pul0), 1);
    chk("stuck_first_err", int'(fe0), 3);
    chk("stuck_err_count", int'(ec0), 1);
    for (int i = 5; i < 20; i++) good(0, 0, 0, 0, 0, 1);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("stuck_done", int'(done0), 1);

    // Illegal at sample 5, then holds with garbage outputs.
    good(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) good(0, 0, 1, i[0], 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    chk("ill_flag", int'(ill0), 1);
    for (int i = 7; i < 11; i++) drive(0, 0, 0, 0, 1, 1, i[0], i[0]);
    for (int i = 11; i < 20; i++) good(0, 0, 1, i[0], 1, 1);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("ill_sticky", int'(ill0), 1);
    chk("ill_no_hold_err", int'(ec0), 0);

    // Every sample wrong: 4-bit counter saturates at 15.
    good(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("all_bad_count8", int'(ec0), 20);
    chk("all_bad_count4", int'(ec2), 15);
    chk("all_bad_first4", int'(fe2), 0);

    // Reset mid-run at sample 10.
    good(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) drive(0, 0, 0, 0, 0, 1, 1, 0);
      else good(0, 0, 1, i[1], 1, 1);
    end
    @(negedge clk);
    chk("pre_rst_err_count", int'(ec0), 1);
    chk("pre_rst_first_err", int'(fe0), 2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_err_count", int'(ec0), 0);
    chk("mid_rst_first_err", int'(fe0), 255);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) good(0, 0, 1, 1, 1, 1);
    @(negedge clk);
    chk("post_rst_idle", int'(busy0), 0);
    good(1, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 1, 1, 1, 0, 1);
    for (int i = 1; i < 20; i++) good(0, 0, 1, i[0], 1, 1);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("fresh_first_err", int'(fe0), 0);
    chk("fresh_err_count", int'(ec0), 1);

    // start during RUN (sample 7) and on the final sample are ignored.
    good(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) good((i == 7) || (i == 19), 0, i[0], i[2], 1, 1);
    @(negedge clk);
    chk("restart_busy", int'(busy0), 1);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("restart_done", int'(done0), 1);
    chk("restart_not_busy", int'(busy0), 0);

    // 255-sample runs: 255 + 45 mismatches.
    good(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 255; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("sat_done", int'(done1), 1);
    chk("sat_err_count", int'(ec1), 255);
    chk("sat_first_err", int'(fe1), 0);
    good(0, 1, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sat_restart_count", int'(ec1), 0);
    chk("sat_restart_busy", int'(busy1), 1);
    for (int i = 1; i < 45; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 45; i < 255; i++) good(0, 0, 0, 0, 0, 1);
    good(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("sat_run2_count", int'(ec1), 45);
    chk("sat_run2_done", int'(done1), 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
